// File: rtl/data_mem_responder_if.sv
// Request/response bus between an initiator and the data memory responder.
// master drives requests and RespReady; slave returns ready, response and error count.
interface data_mem_responder_if;
    logic        ReqValid;
    logic        ReqWE;
    logic [31:0] ReqAddr;
    logic [31:0] ReqWData;
    logic        ReqReady;
    logic        RespValid;
    logic        RespReady;
    logic [31:0] RespRData;
    logic        RespErr;
    logic [7:0]  ErrCount;

    modport master (
        output ReqValid, ReqWE, ReqAddr, ReqWData, RespReady,
        input  ReqReady, RespValid, RespRData, RespErr, ErrCount
    );

    modport slave (
        input  ReqValid, ReqWE, ReqAddr, ReqWData, RespReady,
        output ReqReady, RespValid, RespRData, RespErr, ErrCount
    );
endinterface

// File: rtl/data_mem_responder.sv
// Single-outstanding word memory responder with programmable wait states.
// Ports: Clk, Reset (sync, active-low), bus (slave side of the request/response bus).
module data_mem_responder #(
    parameter int WAIT_CYCLES = 2,
    parameter int DEPTH       = 64
) (
    input  logic                Clk,
    input  logic                Reset,
    data_mem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [7:0]  err_cnt;
    logic [31:0] mem [DEPTH];

    logic          accept;
    logic          enter_resp;
    logic          src_we;
    logic [31:0]   src_addr;
    logic [31:0]   src_wdata;
    logic          fault;
    logic [AW-1:0] idx;

    assign accept = bus.ReqValid && bus.ReqReady;

    // With zero wait cycles the response is built on the accept edge itself,
    // so the live request inputs are used instead of the latched copy.
    always_comb begin
        src_we    = we_q;
        src_addr  = addr_q;
        src_wdata = wdata_q;
        if (state == IDLE) begin
            src_we    = bus.ReqWE;
            src_addr  = bus.ReqAddr;
            src_wdata = bus.ReqWData;
        end
    end

    assign fault = (src_addr[1:0] != 2'b00) ||
                   ({2'b00, src_addr[31:2]} >= 32'(DEPTH));
    assign idx   = src_addr[AW+1:2];

    always_comb begin
        enter_resp = 1'b0;
        if (state == IDLE)
            enter_resp = accept && (WAIT_CYCLES == 0);
        else if (state == WAIT)
            enter_resp = (cnt == 4'd0);
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
            err_cnt <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        we_q    <= bus.ReqWE;
                        addr_q  <= bus.ReqAddr;
                        wdata_q <= bus.ReqWData;
                        if (WAIT_CYCLES == 0) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= 4'(WAIT_CYCLES - 1);
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0)
                        state <= RESP;
                    else
                        cnt <= cnt - 4'd1;
                end
                RESP: begin
                    if (bus.RespReady) begin
                        state <= IDLE;
                        err_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            if (enter_resp) begin
                err_q   <= fault;
                rdata_q <= (!src_we && !fault) ? mem[idx] : 32'd0;
                if (fault && err_cnt != 8'hFF)
                    err_cnt <= err_cnt + 8'd1;
            end
        end
    end

    // Storage is never reset; a reset edge also blocks a pending write.
    always_ff @(posedge Clk) begin
        if (Reset && enter_resp && src_we && !fault)
            mem[idx] <= src_wdata;
    end

    assign bus.ReqReady  = Reset && (state == IDLE);
    assign bus.RespValid = (state == RESP);
    assign bus.RespRData = rdata_q;
    assign bus.RespErr   = err_q && (state == RESP);
    assign bus.ErrCount  = err_cnt;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a 2-wait-state and a 0-wait-state instance.
// Table-driven transactions plus backpressure, mid-wait reset and saturation sequences.
module tb_data_mem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n      [2];
    logic        req_valid  [2];
    logic        req_we     [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic        resp_ready [2];
    logic        req_ready  [2];
    logic        resp_valid [2];
    logic [31:0] resp_rdata [2];
    logic        resp_err   [2];
    logic [7:0]  err_count  [2];

    data_mem_responder_if if0 ();
    data_mem_responder_if if1 ();

    assign if0.ReqValid  = req_valid[0];
    assign if0.ReqWE     = req_we[0];
    assign if0.ReqAddr   = req_addr[0];
    assign if0.ReqWData  = req_wdata[0];
    assign if0.RespReady = resp_ready[0];
    assign req_ready[0]  = if0.ReqReady;
    assign resp_valid[0] = if0.RespValid;
    assign resp_rdata[0] = if0.RespRData;
    assign resp_err[0]   = if0.RespErr;
    assign err_count[0]  = if0.ErrCount;

    assign if1.ReqValid  = req_valid[1];
    assign if1.ReqWE     = req_we[1];
    assign if1.ReqAddr   = req_addr[1];
    assign if1.ReqWData  = req_wdata[1];
    assign if1.RespReady = resp_ready[1];
    assign req_ready[1]  = if1.ReqReady;
    assign resp_valid[1] = if1.RespValid;
    assign resp_rdata[1] = if1.RespRData;
    assign resp_err[1]   = if1.RespErr;
    assign err_count[1]  = if1.ErrCount;

    data_mem_responder #(.WAIT_CYCLES(2), .DEPTH(64)) dut0 (
        .Clk  (clk),
        .Reset(rst_n[0]),
        .bus  (if0)
    );

    data_mem_responder #(.WAIT_CYCLES(0), .DEPTH(64)) dut1 (
        .Clk  (clk),
        .Reset(rst_n[1]),
        .bus  (if1)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // One transaction, starting and ending at a negedge with the DUT idle.
    task automatic xact(input int d, input logic we, input logic [31:0] a,
                        input logic [31:0] w, input int hold,
                        output logic [31:0] rd, output logic er,
                        output int lat, output int unstable);
        int n;
        req_we[d]     = we;
        req_addr[d]   = a;
        req_wdata[d]  = w;
        req_valid[d]  = 1'b1;
        resp_ready[d] = 1'b0;
        n = 0;
        while (!req_ready[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        req_valid[d] = 1'b0;
        req_we[d]    = ~we;
        req_addr[d]  = ~a;
        req_wdata[d] = ~w;
        lat = 0;
        while (!resp_valid[d] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        rd = resp_rdata[d];
        er = resp_err[d];
        unstable = 0;
        for (int i = 0; i < hold; i++) begin
            req_valid[d] = 1'b1;
            req_addr[d]  = req_addr[d] + 32'd4;
            req_wdata[d] = $urandom;
            @(negedge clk);
            if (!resp_valid[d] || resp_rdata[d] !== rd ||
                resp_err[d] !== er || req_ready[d])
                unstable++;
        end
        req_valid[d]  = 1'b0;
        resp_ready[d] = 1'b1;
        @(negedge clk);
        resp_ready[d] = 1'b0;
        chk($sformatf("idle_after_resp_d%0d", d),
            {30'd0, resp_valid[d], req_ready[d]}, 32'd1);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t tbl [11];

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          unst;
        int          nfault;

        tbl[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         1'b0};
        tbl[1]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
        tbl[2]  = '{1'b1, 32'h0000_0004, 32'h0BAD_F00D, 32'h0,         1'b0};
        tbl[3]  = '{1'b1, 32'h0000_0006, 32'hFFFF_FFFF, 32'h0,         1'b1};
        tbl[4]  = '{1'b1, 32'h0000_0100, 32'h0000_0001, 32'h0,         1'b1};
        tbl[5]  = '{1'b0, 32'h0000_0004, 32'h0,         32'h0BAD_F00D, 1'b0};
        tbl[6]  = '{1'b1, 32'h0000_0008, 32'h1111_1111, 32'h0,         1'b0};
        tbl[7]  = '{1'b1, 32'h0000_00FC, 32'hCAFE_F00D, 32'h0,         1'b0};
        tbl[8]  = '{1'b0, 32'h0000_00FC, 32'h0,         32'hCAFE_F00D, 1'b0};
        tbl[9]  = '{1'b0, 32'h0000_0003, 32'h0,         32'h0,         1'b1};
        tbl[10] = '{1'b0, 32'h0000_0008, 32'h0,         32'h1111_1111, 1'b0};

        for (int d = 0; d < 2; d++) begin
            rst_n[d]      = 1'b0;
            req_valid[d]  = 1'b0;
            req_we[d]     = 1'b0;
            req_addr[d]   = 32'd0;
            req_wdata[d]  = 32'd0;
            resp_ready[d] = 1'b0;
        end
        @(negedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_ready_d%0d", d), {31'd0, req_ready[d]}, 32'd0);
            chk($sformatf("rst_valid_d%0d", d), {31'd0, resp_valid[d]}, 32'd0);
            chk($sformatf("rst_rdata_d%0d", d), resp_rdata[d], 32'd0);
            chk($sformatf("rst_err_d%0d", d), {31'd0, resp_err[d]}, 32'd0);
            chk($sformatf("rst_errcnt_d%0d", d), {24'd0, err_count[d]}, 32'd0);
            rst_n[d] = 1'b1;
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++)
            chk($sformatf("ready_after_rst_d%0d", d), {31'd0, req_ready[d]}, 32'd1);

        nfault = 0;
        for (int i = 0; i < 11; i++) begin
            xact(0, tbl[i].we, tbl[i].addr, tbl[i].wdata, 0, rd, er, lat, unst);
            chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
            chk($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, tbl[i].exp_err});
            chk($sformatf("vec%0d_lat", i), lat, 32'd2);
            if (tbl[i].exp_err) nfault++;
        end
        chk("table_errcount", {24'd0, err_count[0]}, nfault);

        xact(0, 1'b0, 32'h0000_0010, 32'h0, 5, rd, er, lat, unst);
        chk("bp_rdata", rd, 32'hDEAD_BEEF);
        chk("bp_lat", lat, 32'd2);
        chk("bp_unstable", unst, 32'd0);

        xact(0, 1'b0, 32'h0000_0104, 32'h0, 3, rd, er, lat, unst);
        chk("bp_fault_err", {31'd0, er}, 32'd1);
        chk("bp_fault_unstable", unst, 32'd0);

        req_we[0]    = 1'b1;
        req_addr[0]  = 32'h0000_0008;
        req_wdata[0] = 32'hA5A5_A5A5;
        req_valid[0] = 1'b1;
        @(negedge clk);
        req_valid[0] = 1'b0;
        @(negedge clk);
        rst_n[0] = 1'b0;
        @(negedge clk);
        chk("midwait_rst_valid", {31'd0, resp_valid[0]}, 32'd0);
        chk("midwait_rst_errcnt", {24'd0, err_count[0]}, 32'd0);
        chk("midwait_rst_ready", {31'd0, req_ready[0]}, 32'd0);
        rst_n[0] = 1'b1;
        @(negedge clk);
        chk("midwait_ready_back", {31'd0, req_ready[0]}, 32'd1);
        repeat (4) @(negedge clk);
        chk("midwait_no_resp", {31'd0, resp_valid[0]}, 32'd0);
        xact(0, 1'b0, 32'h0000_0008, 32'h0, 0, rd, er, lat, unst);
        chk("midwait_retained", rd, 32'h1111_1111);

        xact(1, 1'b1, 32'h0000_0004, 32'h1234_5678, 0, rd, er, lat, unst);
        chk("w0_write_lat", lat, 32'd0);
        chk("w0_write_err", {31'd0, er}, 32'd0);
        xact(1, 1'b0, 32'h0000_0004, 32'h0, 0, rd, er, lat, unst);
        chk("w0_read_lat", lat, 32'd0);
        chk("w0_read_rdata", rd, 32'h1234_5678);

        for (int i = 1; i <= 260; i++) begin
            xact(1, 1'b0, 32'h0000_0001, 32'h0, 0, rd, er, lat, unst);
            if (i == 254)
                chk("sat_254", {24'd0, err_count[1]}, 32'd254);
            if (i == 255)
                chk("sat_255", {24'd0, err_count[1]}, 32'd255);
        end
        chk("sat_260", {24'd0, err_count[1]}, 32'd255);
        chk("sat_last_err", {31'd0, er}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
